// File: rtl/rob_commit.sv
// Reorder buffer commit: in-order retirement of up to 4 done entries per cycle into register-file write ports.
// Latency: completion sampled at edge N retires at N+1; wb_* are registered and valid the cycle after retirement.
// Backpressure: alloc_ready drops below two free entries. Optional flush port under `ROB_FLUSH_EN.
module rob_commit #(
    parameter int DEPTH = 16,
    parameter int XLEN  = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
`ifdef ROB_FLUSH_EN
    input  logic                       flush,
`endif
    input  logic                       alloc_req_0,
    input  logic                       alloc_req_1,
    input  logic [4:0]                 alloc_rd_0,
    input  logic [4:0]                 alloc_rd_1,
    input  logic                       alloc_wr_0,
    input  logic                       alloc_wr_1,
    output logic                       alloc_ready,
    output logic [$clog2(DEPTH)-1:0]   alloc_tag_0,
    output logic [$clog2(DEPTH)-1:0]   alloc_tag_1,
    input  logic                       cpl_valid_0,
    input  logic                       cpl_valid_1,
    input  logic [$clog2(DEPTH)-1:0]   cpl_tag_0,
    input  logic [$clog2(DEPTH)-1:0]   cpl_tag_1,
    input  logic [XLEN-1:0]            cpl_data_0,
    input  logic [XLEN-1:0]            cpl_data_1,
    output logic [4:0]                 wb_idex_0,
    output logic [4:0]                 wb_idex_1,
    output logic [4:0]                 wb_idex_2,
    output logic [4:0]                 wb_idex_3,
    output logic [XLEN-1:0]            wb_data_0,
    output logic [XLEN-1:0]            wb_data_1,
    output logic [XLEN-1:0]            wb_data_2,
    output logic [XLEN-1:0]            wb_data_3,
    output logic                       wb_en_0,
    output logic                       wb_en_1,
    output logic                       wb_en_2,
    output logic                       wb_en_3,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int TW = $clog2(DEPTH);

    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] done_q;
    logic [DEPTH-1:0] wr_q;
    logic [4:0]       rd_q   [DEPTH];
    logic [XLEN-1:0]  data_q [DEPTH];
    logic [TW-1:0]    head_q;
    logic [TW-1:0]    tail_q;
    logic [TW:0]      count_q;

    logic [3:0]       wb_en_q;
    logic [4:0]       wb_idex_q [4];
    logic [XLEN-1:0]  wb_data_q [4];

    logic             do_alloc0;
    logic             do_alloc1;
    logic [1:0]       alloc_n;
    logic [TW-1:0]    tail_p1;
    logic [TW-1:0]    ret_idx [4];
    logic [3:0]       ret_keep;
    logic [2:0]       ret_n;
    logic             run;

    // Readiness comes from the registered count only, so freed slots show up a cycle later.
    assign alloc_ready = count_q <= (TW+1)'(DEPTH - 2);
    assign tail_p1     = tail_q + TW'(1);
    assign alloc_tag_0 = tail_q;
    assign alloc_tag_1 = tail_p1;
    assign count       = count_q;
    assign do_alloc0   = alloc_req_0 && alloc_ready;
    assign do_alloc1   = do_alloc0 && alloc_req_1;
    assign alloc_n     = {1'b0, do_alloc0} + {1'b0, do_alloc1};

    assign wb_en_0   = wb_en_q[0];
    assign wb_en_1   = wb_en_q[1];
    assign wb_en_2   = wb_en_q[2];
    assign wb_en_3   = wb_en_q[3];
    assign wb_idex_0 = wb_idex_q[0];
    assign wb_idex_1 = wb_idex_q[1];
    assign wb_idex_2 = wb_idex_q[2];
    assign wb_idex_3 = wb_idex_q[3];
    assign wb_data_0 = wb_data_q[0];
    assign wb_data_1 = wb_data_q[1];
    assign wb_data_2 = wb_data_q[2];
    assign wb_data_3 = wb_data_q[3];

    // Retire run stops at the first entry that is not both valid and done.
    always_comb begin
        ret_n    = '0;
        run      = 1'b1;
        ret_keep = '0;
        for (int k = 0; k < 4; k++) begin
            ret_idx[k] = head_q + TW'(k);
            if (run && vld_q[ret_idx[k]] && done_q[ret_idx[k]]) begin
                ret_n = 3'(k + 1);
            end else begin
                run = 1'b0;
            end
            ret_keep[k] = run && wr_q[ret_idx[k]] && (rd_q[ret_idx[k]] != 5'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q   <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            wb_en_q <= '0;
            for (int k = 0; k < 4; k++) begin
                wb_idex_q[k] <= '0;
                wb_data_q[k] <= '0;
            end
`ifdef ROB_FLUSH_EN
        end else if (flush) begin
            vld_q   <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            wb_en_q <= '0;
            for (int k = 0; k < 4; k++) begin
                wb_idex_q[k] <= '0;
                wb_data_q[k] <= '0;
            end
`endif
        end else begin
            for (int k = 0; k < 4; k++) begin
                wb_en_q[k]   <= ret_keep[k];
                wb_idex_q[k] <= ret_keep[k] ? rd_q[ret_idx[k]] : 5'd0;
                wb_data_q[k] <= ret_keep[k] ? data_q[ret_idx[k]] : '0;
                if (3'(k) < ret_n) begin
                    vld_q[ret_idx[k]]  <= 1'b0;
                    done_q[ret_idx[k]] <= 1'b0;
                end
            end
            // Port 1 is applied first so port 0 overrides it on a shared tag.
            if (cpl_valid_1 && vld_q[cpl_tag_1] && !done_q[cpl_tag_1]) begin
                done_q[cpl_tag_1] <= 1'b1;
                data_q[cpl_tag_1] <= cpl_data_1;
            end
            if (cpl_valid_0 && vld_q[cpl_tag_0] && !done_q[cpl_tag_0]) begin
                done_q[cpl_tag_0] <= 1'b1;
                data_q[cpl_tag_0] <= cpl_data_0;
            end
            if (do_alloc0) begin
                vld_q[tail_q]  <= 1'b1;
                done_q[tail_q] <= 1'b0;
                rd_q[tail_q]   <= alloc_rd_0;
                wr_q[tail_q]   <= alloc_wr_0;
            end
            if (do_alloc1) begin
                vld_q[tail_p1]  <= 1'b1;
                done_q[tail_p1] <= 1'b0;
                rd_q[tail_p1]   <= alloc_rd_1;
                wr_q[tail_p1]   <= alloc_wr_1;
            end
            head_q  <= head_q + TW'(ret_n);
            tail_q  <= tail_q + TW'(alloc_n);
            count_q <= count_q + (TW+1)'(alloc_n) - (TW+1)'(ret_n);
        end
    end
endmodule

// File: tb/tb_rob_commit.sv
// Bench for rob_commit: directed stimulus, expected writebacks queued with their due edge and checked by a monitor.
module tb_rob_commit;
    logic        clk = 1'b0;
    logic        rst_n;
`ifdef ROB_FLUSH_EN
    logic        flush;
`endif
    logic        alloc_req_0, alloc_req_1, alloc_wr_0, alloc_wr_1;
    logic [4:0]  alloc_rd_0, alloc_rd_1;
    logic        alloc_ready;
    logic [3:0]  alloc_tag_0, alloc_tag_1;
    logic        cpl_valid_0, cpl_valid_1;
    logic [3:0]  cpl_tag_0, cpl_tag_1;
    logic [63:0] cpl_data_0, cpl_data_1;
    logic [4:0]  wb_idex_0, wb_idex_1, wb_idex_2, wb_idex_3;
    logic [63:0] wb_data_0, wb_data_1, wb_data_2, wb_data_3;
    logic        wb_en_0, wb_en_1, wb_en_2, wb_en_3;
    logic [4:0]  count;

    typedef struct {
        int          due;
        int          lane;
        logic [4:0]  idex;
        logic [63:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   tests = 0;
    int   failed = 0;
    int   edge_n = 0;

    wire [3:0]  men = {wb_en_3, wb_en_2, wb_en_1, wb_en_0};
    wire [4:0]  mi [4];
    wire [63:0] md [4];
    assign mi[0] = wb_idex_0;
    assign mi[1] = wb_idex_1;
    assign mi[2] = wb_idex_2;
    assign mi[3] = wb_idex_3;
    assign md[0] = wb_data_0;
    assign md[1] = wb_data_1;
    assign md[2] = wb_data_2;
    assign md[3] = wb_data_3;

    rob_commit #(.DEPTH(16), .XLEN(64)) dut (
        .clk(clk), .rst_n(rst_n),
`ifdef ROB_FLUSH_EN
        .flush(flush),
`endif
        .alloc_req_0(alloc_req_0), .alloc_req_1(alloc_req_1),
        .alloc_rd_0(alloc_rd_0), .alloc_rd_1(alloc_rd_1),
        .alloc_wr_0(alloc_wr_0), .alloc_wr_1(alloc_wr_1),
        .alloc_ready(alloc_ready), .alloc_tag_0(alloc_tag_0), .alloc_tag_1(alloc_tag_1),
        .cpl_valid_0(cpl_valid_0), .cpl_valid_1(cpl_valid_1),
        .cpl_tag_0(cpl_tag_0), .cpl_tag_1(cpl_tag_1),
        .cpl_data_0(cpl_data_0), .cpl_data_1(cpl_data_1),
        .wb_idex_0(wb_idex_0), .wb_idex_1(wb_idex_1), .wb_idex_2(wb_idex_2), .wb_idex_3(wb_idex_3),
        .wb_data_0(wb_data_0), .wb_data_1(wb_data_1), .wb_data_2(wb_data_2), .wb_data_3(wb_data_3),
        .wb_en_0(wb_en_0), .wb_en_1(wb_en_1), .wb_en_2(wb_en_2), .wb_en_3(wb_en_3),
        .count(count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n++;

    // Monitor: every asserted lane must match the head of the expected queue, including its due edge.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 4; k++) begin
                tests++;
                if (men[k]) begin
                    if (sb.size() == 0) begin
                        failed++;
                        $display("FAIL wb_unexpected lane %0d edge %0d: got idex %0d data %h, expected no write", k, edge_n, mi[k], md[k]);
                    end else begin
                        e = sb.pop_front();
                        if (e.lane != k || e.idex != mi[k] || e.data != md[k] || e.due != edge_n) begin
                            failed++;
                            $display("FAIL wb_write: got lane %0d idex %0d data %h edge %0d, expected lane %0d idex %0d data %h edge %0d",
                                     k, mi[k], md[k], edge_n, e.lane, e.idex, e.data, e.due);
                        end
                    end
                end else if (mi[k] != 5'd0 || md[k] != 64'd0) begin
                    failed++;
                    $display("FAIL wb_idle lane %0d: got idex %0d data %h, expected 0/0", k, mi[k], md[k]);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called in the drive cycle: sampled at the next edge, retired one edge later, visible after that.
    task automatic push(input int lane, input logic [4:0] idex, input logic [63:0] data);
        exp_t x;
        x.due  = edge_n + 2;
        x.lane = lane;
        x.idex = idex;
        x.data = data;
        sb.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        alloc_req_0 = 1'b0;
        alloc_req_1 = 1'b0;
        cpl_valid_0 = 1'b0;
        cpl_valid_1 = 1'b0;
`ifdef ROB_FLUSH_EN
        flush = 1'b0;
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic alloc2(input logic [4:0] r0, input logic w0, input logic req1, input logic [4:0] r1, input logic w1);
        alloc_req_0 = 1'b1;
        alloc_rd_0  = r0;
        alloc_wr_0  = w0;
        alloc_req_1 = req1;
        alloc_rd_1  = r1;
        alloc_wr_1  = w1;
    endtask

    task automatic cpl2(input logic v0, input logic [3:0] t0, input logic [63:0] d0,
                        input logic v1, input logic [3:0] t1, input logic [63:0] d1);
        cpl_valid_0 = v0;
        cpl_tag_0   = t0;
        cpl_data_0  = d0;
        cpl_valid_1 = v1;
        cpl_tag_1   = t1;
        cpl_data_1  = d1;
    endtask

    initial begin
        rst_n = 1'b0;
        alloc_req_0 = 0; alloc_req_1 = 0; alloc_wr_0 = 0; alloc_wr_1 = 0;
        alloc_rd_0 = 0; alloc_rd_1 = 0;
        cpl_valid_0 = 0; cpl_valid_1 = 0; cpl_tag_0 = 0; cpl_tag_1 = 0;
        cpl_data_0 = 0; cpl_data_1 = 0;
`ifdef ROB_FLUSH_EN
        flush = 0;
`endif
        tick();
        tick();
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_ready", 64'(alloc_ready), 64'd1);
        chk("rst_tag0", 64'(alloc_tag_0), 64'd0);
        chk("rst_tag1", 64'(alloc_tag_1), 64'd1);
        chk("rst_wb_en", 64'(men), 64'd0);
        chk("rst_wb_data0", wb_data_0, 64'd0);
        rst_n = 1'b1;

        // Single instruction: rd 5 completes with 0xDEAD.
        alloc2(5'd5, 1'b1, 1'b0, 5'd0, 1'b0);
        chk("single_tag", 64'(alloc_tag_0), 64'd0);
        tick();
        chk("single_count", 64'(count), 64'd1);
        cpl2(1'b1, 4'd0, 64'hDEAD, 1'b0, 4'd0, 64'd0);
        push(0, 5'd5, 64'hDEAD);
        tick();
        idle(4);
        chk("single_drain", 64'(count), 64'd0);

        // Out-of-order completion 3,1,0,2,4,5; tags 2 and 3 share rd 12.
        do_reset();
        for (int p = 0; p < 3; p++) begin
            alloc2(5'(10 + 2 * p), 1'b1, 1'b1, (p == 1) ? 5'd12 : 5'(11 + 2 * p), 1'b1);
            tick();
        end
        chk("ooo_count", 64'(count), 64'd6);
        cpl2(1'b1, 4'd3, 64'h103, 1'b1, 4'd1, 64'h101);
        tick();
        cpl2(1'b1, 4'd0, 64'h100, 1'b1, 4'd2, 64'h102);
        push(0, 5'd10, 64'h100);
        push(1, 5'd11, 64'h101);
        push(2, 5'd12, 64'h102);
        push(3, 5'd12, 64'h103);
        tick();
        cpl2(1'b1, 4'd4, 64'h104, 1'b1, 4'd5, 64'h105);
        push(0, 5'd14, 64'h104);
        push(1, 5'd15, 64'h105);
        tick();
        idle(4);
        chk("ooo_drain", 64'(count), 64'd0);

        // Fill to full, refused allocation, then retire-and-allocate together.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            alloc2(5'(2 * i + 1), 1'b1, 1'b1, 5'(2 * i + 2), 1'b1);
            tick();
        end
        chk("full_count", 64'(count), 64'd16);
        chk("full_ready", 64'(alloc_ready), 64'd0);
        alloc2(5'd29, 1'b1, 1'b1, 5'd28, 1'b1);
        tick();
        chk("full_ignored_count", 64'(count), 64'd16);
        chk("full_wrap_tag0", 64'(alloc_tag_0), 64'd0);
        cpl2(1'b1, 4'd0, 64'h50, 1'b1, 4'd1, 64'h51);
        push(0, 5'd1, 64'h50);
        push(1, 5'd2, 64'h51);
        tick();
        chk("full_still_count", 64'(count), 64'd16);
        chk("full_still_ready", 64'(alloc_ready), 64'd0);
        tick();
        chk("freed_count", 64'(count), 64'd14);
        chk("freed_ready", 64'(alloc_ready), 64'd1);
        alloc2(5'd30, 1'b1, 1'b1, 5'd31, 1'b1);
        chk("freed_tag1", 64'(alloc_tag_1), 64'd1);
        cpl2(1'b1, 4'd2, 64'h52, 1'b1, 4'd3, 64'h53);
        push(0, 5'd3, 64'h52);
        push(1, 5'd4, 64'h53);
        tick();
        chk("refill_count", 64'(count), 64'd16);
        tick();
        chk("mixed_count", 64'(count), 64'd14);
        idle(2);

        // rd=0 and wr=0 retire silently; a following write still lands.
        do_reset();
        alloc2(5'd0, 1'b1, 1'b1, 5'd7, 1'b0);
        tick();
        alloc2(5'd9, 1'b1, 1'b0, 5'd0, 1'b0);
        tick();
        cpl2(1'b1, 4'd0, 64'h1234, 1'b1, 4'd1, 64'h55);
        tick();
        cpl2(1'b1, 4'd2, 64'h99, 1'b0, 4'd0, 64'd0);
        push(0, 5'd9, 64'h99);
        tick();
        idle(4);
        chk("rd0_drain", 64'(count), 64'd0);

        // Both completion ports on tag 7: port 0 data must win.
        do_reset();
        for (int p = 0; p < 4; p++) begin
            alloc2(5'd20, 1'b1, 1'b1, 5'd20, 1'b1);
            tick();
        end
        cpl2(1'b1, 4'd7, 64'hA, 1'b1, 4'd7, 64'hB);
        tick();
        chk("prio_count", 64'(count), 64'd8);
        for (int p = 0; p < 3; p++) begin
            cpl2(1'b1, 4'(2 * p), 64'(32'h200 + 2 * p), 1'b1, 4'(2 * p + 1), 64'(32'h201 + 2 * p));
            push(0, 5'd20, 64'(32'h200 + 2 * p));
            push(1, 5'd20, 64'(32'h201 + 2 * p));
            tick();
        end
        cpl2(1'b1, 4'd6, 64'h206, 1'b0, 4'd0, 64'd0);
        push(0, 5'd20, 64'h206);
        push(1, 5'd20, 64'hA);
        tick();
        idle(4);
        chk("prio_drain", 64'(count), 64'd0);

`ifdef ROB_FLUSH_EN
        // Flush on the edge where eight done entries would start retiring.
        do_reset();
        for (int p = 0; p < 4; p++) begin
            alloc2(5'd21, 1'b1, 1'b1, 5'd22, 1'b1);
            tick();
        end
        for (int p = 0; p < 3; p++) begin
            cpl2(1'b1, 4'(2 * p + 1), 64'h300, 1'b1, 4'(2 * p + 2), 64'h301);
            tick();
        end
        cpl2(1'b1, 4'd7, 64'h307, 1'b0, 4'd0, 64'd0);
        tick();
        cpl2(1'b1, 4'd0, 64'h308, 1'b0, 4'd0, 64'd0);
        tick();
        flush = 1'b1;
        tick();
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_tag0", 64'(alloc_tag_0), 64'd0);
        idle(3);
        alloc2(5'd3, 1'b1, 1'b0, 5'd0, 1'b0);
        chk("flush_next_tag", 64'(alloc_tag_0), 64'd0);
        tick();
        chk("flush_next_count", 64'(count), 64'd1);
`endif

        idle(2);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/rob_commit.md
ROB_COMMIT -- requirements
Module: rob_commit

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of entries (power of two, 4..64).
REQ-002 SHALL have parameter XLEN, default 64, result data width.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 SHALL have ports alloc_req_0/1  in  1  allocation request; lane 0 is older.
REQ-006 SHALL have ports alloc_rd_0/1  in  5  destination architectural register.
REQ-007 SHALL have ports alloc_wr_0/1  in  1  instruction writes rd.
REQ-008 SHALL have port alloc_ready  out  1  at least two entries free.
REQ-009 SHALL have ports alloc_tag_0/1  out  log2(DEPTH)  tag given to lane 0/1; alloc_tag_1 = alloc_tag_0+1 mod DEPTH.
REQ-010 SHALL have ports cpl_valid_0/1  in  1, cpl_tag_0/1  in  log2(DEPTH), cpl_data_0/1  in  XLEN; completion ports.
REQ-011 SHALL have ports wb_idex_0..3  out  5, wb_data_0..3  out  XLEN, wb_en_0..3  out  1; retirement write ports into the architectural register file, lane 0 oldest.
REQ-012 SHALL have port count  out  log2(DEPTH)+1  occupied entries.

Function
REQ-013 SHALL be a circular buffer with head (oldest) and tail pointers; each entry holds valid, done, rd, wr, data.
REQ-014 SHALL allocate only when alloc_ready=1; lane 0 takes tail, lane 1 takes tail+1; alloc_req_1 without alloc_req_0 SHALL be ignored.
REQ-015 SHALL derive alloc_ready from registered count (DEPTH-count >= 2); entries freed this cycle are reusable next cycle.
REQ-016 SHALL, on cpl_valid for a valid, not-done entry, store cpl_data and set done at the clock edge; completions to invalid or done entries SHALL be ignored.
REQ-017 SHALL give cpl port 0 priority when both ports carry the same tag in one cycle.
REQ-018 SHALL each cycle retire the longest run, max 4, of consecutive valid&done entries starting at head; retirement never skips a not-done entry.
REQ-019 SHALL register wb_* outputs: entries retired at edge N drive wb_* during cycle N+1; completion sampled at edge N is retireable at edge N+1, giving wb_en at N+2.
REQ-020 SHALL drive wb_en_k=1 only for a retired entry with wr=1 and rd!=0; unused lanes drive wb_en=0, wb_idex=0, wb_data=0.
REQ-021 SHALL, for rd=0 or wr=0 retirement, drive wb_idex=0, wb_data=0, wb_en=0, so register file writes to index 0 always store zero.
REQ-022 SHALL keep program order across lanes so that two retirements to the same rd in one bundle are resolved by the higher lane (younger) winning.
REQ-023 SHALL update count = count + allocated - retired in the same edge; simultaneous allocation, completion and retirement on a full or empty buffer SHALL be handled without loss.
REQ-024 SHALL wrap pointers modulo DEPTH.

Reset
REQ-025 SHALL on rst_n=0 clear all valid/done bits, head=tail=0, count=0, alloc_ready=1, alloc_tag_0=0, alloc_tag_1=1, all wb_* outputs 0.
REQ-026 SHALL have reset override all same-cycle allocation, completion and retirement.

Configuration
REQ-027 SHALL, with ROB_FLUSH_EN defined, add input port flush (1 bit), which clears the buffer exactly as reset does except wb_* outputs are driven 0 the next cycle, and SHALL ignore same-cycle allocation, completion and retirement.
REQ-028 SHALL, without ROB_FLUSH_EN, omit the flush port and all flush logic.

Verification
REQ-029 SHALL cover: reset, then alloc rd=5,wr=1 with tag 0, then cpl tag 0 with data 0xDEAD -> wb_en_0=1, wb_idex_0=5, wb_data_0=0xDEAD two cycles after the completion.
REQ-030 SHALL cover: allocate tags 0..5, complete in order 3,1,0,2,4,5 -> no wb_en until tag 0 completes, then tags 0..3 retire in one bundle on lanes 0..3, then 4,5.
REQ-031 SHALL cover: fill 16 entries -> alloc_ready=0, count=16; further alloc_req ignored; retiring 2 entries restores alloc_ready the following cycle.
REQ-032 SHALL cover: retire rd=0 with data 0x1234 and wr=1 -> wb_idex=0, wb_data=0, wb_en=0.
REQ-033 SHALL cover: both cpl ports on tag 7 with data 0xA/0xB -> 0xA retired; with ROB_FLUSH_EN, flush with 8 done entries -> count=0, no wb_en, next allocation gets tag 0.
